load_engine: RTL and testbench

//  Parametrised LOAD_V/LOAD_M execution engine. Fetches bytes directly over a MEM_WIDTH-bit memory port.

---
 rtl/load_engine_pkg.sv | 30 +++
 rtl/load_engine_tile_packer.sv | 56 +++++
 rtl/load_engine.sv | 193 +++++++++++++++++++
 tb/tb_load_engine.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_engine_pkg.sv
`default_nettype none
// ============================================================================
// Package : load_engine_pkg
// Brief   : Opcodes, FSM state encoding and helpers shared by the load engine.
// Rev     : 1.0 - initial release
// ============================================================================
package load_engine_pkg;

    localparam logic [4:0] OP_LOAD_V = 5'h01;
    localparam logic [4:0] OP_LOAD_M = 5'h02;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        EMIT     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    function automatic logic [15:0] min3(input logic [15:0] a,
                                         input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0] m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_engine_tile_packer.sv
`default_nettype none
// ============================================================================
// Module : tile_packer
// Brief  : Byte-lane accumulator; appends the low nbytes lanes of a beat at the
//          current fill position. Unwritten elements stay zero until clear.
// Rev    : 1.0 - initial release
// ============================================================================
module tile_packer
    import load_engine_pkg::*;
#(
    parameter int TILE_WIDTH = 256,
    parameter int MEM_WIDTH  = 64,
    parameter int TILE_ELEMS = TILE_WIDTH / 8,
    parameter int MEM_BYTES  = MEM_WIDTH / 8,
    parameter int FILL_W     = $clog2(TILE_ELEMS + 1),
    parameter int NB_W       = $clog2(MEM_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [NB_W-1:0]       nbytes,
    input  logic [MEM_WIDTH-1:0]  beat,
    output logic [FILL_W-1:0]     fill,
    output logic [TILE_WIDTH-1:0] data
);

    logic [TILE_WIDTH-1:0] r_acc;
    logic [FILL_W-1:0]     r_fill;
    logic [TILE_WIDTH-1:0] w_lanes;
    logic [TILE_WIDTH-1:0] w_shifted;

    // Lanes at or above nbytes are masked so the accumulator keeps its zero pad.
    always_comb begin
        w_lanes = '0;
        for (int k = 0; k < MEM_BYTES; k++) begin
            if (k < int'(nbytes)) w_lanes[8*k +: 8] = beat[8*k +: 8];
        end
        w_shifted = w_lanes << {r_fill, 3'b000};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (load) begin
            r_acc  <= r_acc | w_shifted;
            r_fill <= r_fill + FILL_W'(nbytes);
        end
    end

    assign fill = r_fill;
    assign data = r_acc;

endmodule
`default_nettype wire

// File: rtl/load_engine.sv
`default_nettype none
// ============================================================================
// Module : load_engine
// Brief  : LOAD_V / LOAD_M engine: fetches memory beats, packs them into tiles
//          and hands tiles to the buffer controller over valid/ready.
// Config : LOAD_STRIDE_EN adds the row_stride port (matrix row pitch).
// Rev    : 1.0 - initial release
// ============================================================================
module load_engine
    import load_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int MEM_WIDTH  = 64,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            opcode,
    input  logic [4:0]            dest_buffer_id,
    input  logic [9:0]            length_or_cols,
    input  logic [9:0]            rows,
    input  logic [ADDR_WIDTH-1:0] addr,
`ifdef LOAD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] row_stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic                  tile_is_matrix,
    output logic [4:0]            tile_buffer_id,
    output logic [9:0]            tile_index,
    output logic [TILE_WIDTH-1:0] tile_data,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_valid
);

    localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
    localparam int MEM_BYTES  = MEM_WIDTH / 8;
    localparam int FILL_W     = $clog2(TILE_ELEMS + 1);
    localparam int NB_W       = $clog2(MEM_BYTES + 1);

    generate
        if (DATA_WIDTH != 8 || (TILE_ELEMS % MEM_BYTES) != 0) begin : g_param_check
            $error("load_engine: DATA_WIDTH must be 8 and MEM_BYTES must divide TILE_ELEMS");
        end
    endgenerate

    state_t                r_state, w_next;
    logic                  r_is_matrix;
    logic                  r_err;
    logic [4:0]            r_buf_id;
    logic [9:0]            r_cols;
    logic [9:0]            r_row_rem;
    logic [9:0]            r_rows_rem;
    logic [9:0]            r_tile_index;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_pitch;

    logic                  w_op_valid;
    logic                  w_zero;
    logic [ADDR_WIDTH-1:0] w_pitch_in;
    logic [FILL_W-1:0]     w_fill;
    logic [15:0]           w_take;
    logic                  w_tile_full;
    logic                  w_row_end;
    logic                  w_load;
    logic                  w_clear;

    assign w_op_valid = (opcode == OP_LOAD_V) || (opcode == OP_LOAD_M);
    assign w_zero     = (length_or_cols == 10'd0) ||
                        ((opcode == OP_LOAD_M) && (rows == 10'd0));
`ifdef LOAD_STRIDE_EN
    assign w_pitch_in = row_stride;
`else
    assign w_pitch_in = ADDR_WIDTH'(length_or_cols);
`endif

    // Bytes consumed from one beat: bounded by beat size, row remainder, tile space.
    assign w_take      = min3(16'(MEM_BYTES), {6'd0, r_row_rem},
                              16'(TILE_ELEMS) - 16'(w_fill));
    assign w_tile_full = (16'(w_fill) + w_take) == 16'(TILE_ELEMS);
    assign w_row_end   = (w_take == {6'd0, r_row_rem});
    assign w_load      = (r_state == FETCH) && mem_valid;
    assign w_clear     = (r_state == EMIT) && tile_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        mem_req    = 1'b0;
        tile_valid = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = (!w_op_valid || w_zero) ? COMPLETE : FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_valid && (w_tile_full || w_row_end)) w_next = EMIT;
            end
            EMIT: begin
                tile_valid = 1'b1;
                if (tile_ready)
                    w_next = (r_row_rem != 10'd0 || r_rows_rem > 10'd1) ? FETCH : COMPLETE;
            end
            COMPLETE: begin
                done   = 1'b1;
                error  = r_err;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_matrix  <= 1'b0;
            r_err        <= 1'b0;
            r_buf_id     <= '0;
            r_cols       <= '0;
            r_row_rem    <= '0;
            r_rows_rem   <= '0;
            r_tile_index <= '0;
            r_addr       <= '0;
            r_row_base   <= '0;
            r_pitch      <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_is_matrix  <= (opcode == OP_LOAD_M);
                    r_err        <= !w_op_valid;
                    r_buf_id     <= dest_buffer_id;
                    r_cols       <= length_or_cols;
                    r_row_rem    <= length_or_cols;
                    r_rows_rem   <= (opcode == OP_LOAD_M) ? rows : 10'd1;
                    r_tile_index <= '0;
                    r_addr       <= addr;
                    r_row_base   <= addr;
                    r_pitch      <= w_pitch_in;
                end
                FETCH: if (mem_valid) begin
                    r_addr    <= r_addr + ADDR_WIDTH'(w_take);
                    r_row_rem <= r_row_rem - w_take[9:0];
                end
                EMIT: if (tile_ready) begin
                    r_tile_index <= r_tile_index + 10'd1;
                    // A finished row with rows left restarts at the next row base.
                    if (r_row_rem == 10'd0 && r_rows_rem > 10'd1) begin
                        r_rows_rem <= r_rows_rem - 10'd1;
                        r_row_base <= r_row_base + r_pitch;
                        r_addr     <= r_row_base + r_pitch;
                        r_row_rem  <= r_cols;
                    end
                end
                default: ;
            endcase
        end
    end

    tile_packer #(
        .TILE_WIDTH (TILE_WIDTH),
        .MEM_WIDTH  (MEM_WIDTH)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .load   (w_load),
        .nbytes (NB_W'(w_take)),
        .beat   (mem_rdata),
        .fill   (w_fill),
        .data   (tile_data)
    );

    assign tile_is_matrix = r_is_matrix;
    assign tile_buffer_id = r_buf_id;
    assign tile_index     = r_tile_index;
    assign mem_addr       = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_load_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_load_engine
// Brief  : Randomized bench for load_engine with a tile/beat reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_load_engine;

    localparam int AW = 24;
    localparam int TW = 256;
    localparam int MW = 64;
    localparam int TE = 32;
    localparam int MB = 8;
    localparam logic [4:0] OPV = 5'h01;
    localparam logic [4:0] OPM = 5'h02;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [4:0]    opcode, dest_buffer_id;
    logic [9:0]    length_or_cols, rows;
    logic [AW-1:0] addr;
`ifdef LOAD_STRIDE_EN
    logic [AW-1:0] row_stride;
`endif
    logic          busy, done, error, tile_valid, tile_ready, tile_is_matrix;
    logic [4:0]    tile_buffer_id;
    logic [9:0]    tile_index;
    logic [TW-1:0] tile_data;
    logic          mem_req, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_rdata;

    load_engine #(.DATA_WIDTH(8), .TILE_WIDTH(TW), .MEM_WIDTH(MW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .dest_buffer_id(dest_buffer_id), .length_or_cols(length_or_cols),
        .rows(rows), .addr(addr),
`ifdef LOAD_STRIDE_EN
        .row_stride(row_stride),
`endif
        .busy(busy), .done(done), .error(error), .tile_valid(tile_valid),
        .tile_ready(tile_ready), .tile_is_matrix(tile_is_matrix),
        .tile_buffer_id(tile_buffer_id), .tile_index(tile_index),
        .tile_data(tile_data), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] exp_tiles[$];
    logic [AW-1:0] exp_beats[$];
    int            exp_nbeats[$];

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory content is a fixed function of the byte address.
    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return (lo * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    // Each tile covers one TE-element slice of a row; its beats step by MB bytes.
    task automatic build_model(input logic [4:0] op, input int len, input int nrows,
                               input logic [AW-1:0] base);
        logic [AW-1:0] pitch, rb;
        logic [TW-1:0] tile;
        int nr, nb;
        exp_tiles.delete(); exp_beats.delete(); exp_nbeats.delete();
        nr = (op == OPM) ? nrows : 1;
`ifdef LOAD_STRIDE_EN
        pitch = row_stride;
`else
        pitch = AW'(len);
`endif
        if ((op == OPV || op == OPM) && len > 0 && nr > 0) begin
            for (int r = 0; r < nr; r++) begin
                rb = base + AW'(r) * pitch;
                for (int t = 0; t * TE < len; t++) begin
                    tile = '0;
                    nb   = 0;
                    for (int i = 0; i < TE; i++)
                        if (t * TE + i < len) tile[8*i +: 8] = mem_byte(rb + AW'(t * TE + i));
                    for (int c = t * TE; c < len && c < (t + 1) * TE; c += MB) begin
                        exp_beats.push_back(rb + AW'(c));
                        nb++;
                    end
                    exp_tiles.push_back(tile);
                    exp_nbeats.push_back(nb);
                end
            end
        end
    endtask

    task automatic run_cmd(input logic [4:0] op, input int len, input int nrows,
                           input logic [AW-1:0] base, input logic [4:0] bid, input bit stall);
        int tile_no, beats_in_tile, mreq_cycles, stall_cnt, cyc;
        bit expect_tv, expect_done, finished, work, bad_op;
        build_model(op, len, nrows, base);
        bad_op = (op != OPV && op != OPM);
        work   = (exp_tiles.size() > 0);
        @(negedge clk);
        start = 1'b1; opcode = op; length_or_cols = 10'(len); rows = 10'(nrows);
        addr = base; dest_buffer_id = bid; mem_valid = 1'b0; tile_ready = 1'b0;
        tile_no = 0; beats_in_tile = 0; mreq_cycles = 0; stall_cnt = 0; cyc = 0;
        expect_tv = 0; expect_done = 0; finished = 0;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) begin
                check("busy_after_start", busy, 1);
                if (work) check("mem_req_latency", mem_req, 1);
            end
            if (expect_tv)   begin check("tile_after_last_beat", tile_valid, 1); expect_tv = 0; end
            if (expect_done) begin check("done_after_last_tile", done, 1); expect_done = 0; end
            if (done) begin
                check("error_flag", error, bad_op);
                if (!work) check("done_latency", cyc <= 2, 1);
                finished = 1;
            end
            if (tile_valid) begin
                check("no_req_in_emit", mem_req, 0);
                if (tile_no >= exp_tiles.size()) begin
                    check("tile_count_over", tile_no, exp_tiles.size());
                    tile_ready = 1'b1;
                end else begin
                    check("tile_data", tile_data, exp_tiles[tile_no]);
                    check("tile_index", tile_index, tile_no);
                    if (stall && tile_no == 0 && stall_cnt < 5) begin
                        tile_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        tile_ready = 1'($urandom_range(0, 1));
                    end
                    if (tile_ready) begin
                        check("tile_is_matrix", tile_is_matrix, op == OPM);
                        check("tile_buffer_id", tile_buffer_id, bid);
                        tile_no++;
                        beats_in_tile = 0;
                        if (tile_no == exp_tiles.size()) expect_done = 1;
                    end
                end
            end else begin
                tile_ready = 1'($urandom_range(0, 1));
            end
            if (mem_req) begin
                mreq_cycles++;
                mem_valid = ($urandom_range(0, 2) != 0);
                if (mem_valid) begin
                    if (exp_beats.size() == 0) begin
                        check("extra_beat_req", mem_req, 0);
                    end else begin
                        check("beat_addr", mem_addr, exp_beats.pop_front());
                        beats_in_tile++;
                        if (tile_no < exp_nbeats.size() && beats_in_tile == exp_nbeats[tile_no])
                            expect_tv = 1;
                    end
                    for (int k = 0; k < MB; k++) mem_rdata[8*k +: 8] = mem_byte(mem_addr + AW'(k));
                end
            end else begin
                // Stray beats outside a request must be ignored.
                mem_valid = 1'($urandom_range(0, 1));
                mem_rdata = {$urandom, $urandom};
            end
            if (busy && !done && $urandom_range(0, 3) == 0) begin
                start = 1'b1; opcode = 5'($urandom); addr = AW'($urandom);
                length_or_cols = 10'($urandom); rows = 10'($urandom);
                dest_buffer_id = 5'($urandom);
`ifdef LOAD_STRIDE_EN
                row_stride = AW'($urandom);
`endif
            end
            if (cyc > 3000) begin
                check("cmd_timeout", done, 1);
                finished = 1;
            end
        end
        @(negedge clk);
        start = 1'b0; mem_valid = 1'b0; tile_ready = 1'b0;
        check("done_single_pulse", done, 0);
        check("idle_after_done", busy, 0);
        check("tiles_delivered", tile_no, exp_tiles.size());
        check("beats_all_issued", exp_beats.size(), 0);
        if (!work) check("no_mem_req", mreq_cycles, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_tile_valid"}, tile_valid, 0);
        check({tag, "_tile_index"}, tile_index, 0);
        check({tag, "_tile_data"}, tile_data, 0);
        check({tag, "_tile_matrix"}, tile_is_matrix, 0);
        check({tag, "_tile_buf"}, tile_buffer_id, 0);
    endtask

    initial begin
        logic [4:0] op;
        int len;
        rst = 1'b1; start = 1'b0; opcode = '0; dest_buffer_id = '0;
        length_or_cols = '0; rows = '0; addr = '0; tile_ready = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0;
`ifdef LOAD_STRIDE_EN
        row_stride = '0;
`endif
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_cmd(OPV, 40, 0, 24'h000100, 5'd4, 1'b0);
`ifndef LOAD_STRIDE_EN
        run_cmd(OPM, 20, 3, 24'h000000, 5'd9, 1'b0);
`endif
        run_cmd(OPV, 10, 0, 24'h003000, 5'd1, 1'b1);
        run_cmd(OPV, 0, 0, 24'h000500, 5'd2, 1'b0);
        run_cmd(OPM, 5, 0, 24'h000600, 5'd3, 1'b0);
        run_cmd(5'h07, 12, 2, 24'h000700, 5'd5, 1'b0);

        // Abort a command while it is fetching.
        @(negedge clk);
        start = 1'b1; opcode = OPV; length_or_cols = 10'd64; addr = 24'h000200;
        dest_buffer_id = 5'd6; mem_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("abort_mem_req", mem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        run_cmd(OPV, 33, 0, 24'h000800, 5'd7, 1'b0);

`ifdef LOAD_STRIDE_EN
        row_stride = 24'd16;
        run_cmd(OPM, 4, 2, 24'h000040, 5'd8, 1'b0);
        row_stride = 24'd3;
        run_cmd(OPM, 10, 3, 24'h000900, 5'd10, 1'b0);
        row_stride = 24'd20;
        run_cmd(OPM, 20, 3, 24'h000000, 5'd9, 1'b0);
`endif
        run_cmd(OPV, 37, 0, 24'hFFFFF0, 5'd11, 1'b0);

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 9))
                0:       op = 5'h1F;
                1, 2, 3: op = OPV;
                default: op = OPM;
            endcase
            len = (op == 5'h1F) ? int'($urandom_range(1, 80)) : int'($urandom_range(0, 80));
`ifdef LOAD_STRIDE_EN
            row_stride = AW'($urandom_range(0, 100));
`endif
            run_cmd(op, len, int'($urandom_range(0, 3)), AW'($urandom),
                    5'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
